alu_issue_stage: RTL
====================

Name: alu_issue_stage

Overview:
- Upstream issue/writeback stage for the base integer ALU. Accepts one 32-bit RV32I instruction at a time via a valid/ready handshake and decodes OP (0110011) and OP-IMM (0010011).
- Reads operands from an internal 32x32 register file, drives the ALU's enable/funct3/operand inputs for one cycle, captures the registered ALU result, and writes it back to rd.
- Turns the combinational-per-edge ALU into a sequenced, handshaked execute loop.

Parameters:
- RESET_PC_TAG, 32'h0, value loaded into last_instr debug register on reset.
- NUM_REGS, 32, register count (fixed architectural; parameter only for bench visibility).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous, active-low reset.
- instr_valid  input  1  upstream offers instruction.
- instr_ready  output  1  stage can accept (high only in IDLE).
- instruction  input  32  instruction word, sampled on accept.
- alu_enable  output  1  ALU enable, high exactly one cycle per legal instruction.
- alu_funct3  output  3  ALU operation select.
- alu_operand_1  output  32  rs1 value.
- alu_operand_2  output  32  rs2 value or sign-extended imm / shamt.
- alu_result  input  32  ALU registered output.
- done  output  1  one-cycle pulse when writeback completes.
- illegal  output  1  one-cycle pulse on rejected instruction.
- dbg_addr  input  5  debug read address.
- dbg_data  output  32  combinational register read (x0 reads 0).

Behaviour:
- Reset (async, reset_n=0): state=IDLE; all 32 registers=0; instr_ready=1 after release; alu_enable=0; alu_funct3=0; alu_operand_1/2=0; done=0; illegal=0. Reset mid-operation aborts the instruction with no writeback.
- FSM states: IDLE, ISSUE, WAIT, WB.
- IDLE: instr_ready=1. On instr_valid&instr_ready, latch instruction and decode.
  - Legal: go to ISSUE.
  - Illegal: pulse illegal next cycle, stay IDLE, no register change.
- Legal set:
  - OP with funct7=0000000, any funct3.
  - OP-IMM with funct3 not 001/101.
  - OP-IMM funct3=001 with imm[11:5]=0 (SLLI).
  - OP-IMM funct3=101 with imm[11:5]=0 (SRLI).
  - Everything else is illegal, including SUB, SRA and SRAI (funct7=0100000), which the ALU does not implement, and all other opcodes.
- ISSUE (1 cycle): alu_enable=1; alu_funct3=funct3.
  - alu_operand_1=regfile[rs1].
  - alu_operand_2 for OP: regfile[rs2]; for shift funct3 001/101, zero-extended regfile[rs2][4:0].
  - alu_operand_2 for OP-IMM: sign-extended imm[11:0]; for shifts, zero-extended imm[4:0].
  - Operands are registered outputs, stable from ISSUE through WAIT.
- WAIT (1 cycle): alu_enable=0; operands held. The ALU captured its result at the ISSUE edge.
- WB (1 cycle): write alu_result to rd if rd!=0; pulse done. Next state IDLE. alu_result is sampled only in WB, because outside enabled edges the ALU drives high-Z.
- Latency: accept edge to done pulse = 3 cycles (ISSUE, WAIT, WB). Throughput is 1 instruction per 4 cycles.
- x0: writes are discarded, reads return 0, including dbg_data.
- Read-after-write: writeback completes before the next accept, so no forwarding is needed. An instruction accepted the cycle after done sees the updated value.
- instr_valid while not ready: ignored. Upstream holds the instruction; no data is lost.
- Simultaneous dbg read and write of the same register: dbg_data shows the old value until the edge.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) -> alu_enable one cycle with funct3=0, op1=0, op2=5. done 3 cycles after accept; dbg x1=5.
- With x1=5: ADDI x2,x0,-1 then SLTU x3,x1,x2 -> x2=32'hFFFFFFFF, x3=1. SLT x4,x1,x2 -> x4=0.
- SLL x5,x1,x6 with x6=32'h00000021 -> op2 masked to 1, x5=10. SLLI x7,x1,31 -> x7=32'h80000000.
- SUB x1,x1,x1 (0x401080B3) -> illegal pulses one cycle, no alu_enable, x1 unchanged at 5. Also a LW opcode -> illegal.
- ADDI x0,x1,7 -> done pulses, dbg x0 reads 0. instr_valid held high across back-to-back instructions -> instr_ready low during ISSUE/WAIT/WB, and each instruction executes exactly once.
- Assert reset_n low during WAIT of ORI x8,x0,0x7FF -> immediate IDLE, no done pulse, x8=0, all registers 0.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue/writeback sequencer for the base integer ALU: decodes OP / OP-IMM, reads the
// register file, drives the ALU for one cycle and writes its registered result back to rd.
module alu_issue_stage #(
  parameter logic [31:0] RESET_PC_TAG = 32'h0,
  parameter int unsigned NUM_REGS     = 32
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic [31:0] instruction,
  output logic        alu_enable,
  output logic [2:0]  alu_funct3,
  output logic [31:0] alu_operand_1,
  output logic [31:0] alu_operand_2,
  input  logic [31:0] alu_result,
  output logic        done,
  output logic        illegal,
  input  logic [4:0]  dbg_addr,
  output logic [31:0] dbg_data
);

  typedef enum logic [1:0] {StIdle, StIssue, StWait, StWb} state_e;

  state_e      state_q, state_d;
  logic [31:0] instr_q, instr_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [31:0] op1_q, op1_d;
  logic [31:0] op2_q, op2_d;
  logic        illegal_q, illegal_d;
  logic [31:0] regs_q [NUM_REGS];
  logic [31:0] regs_d [NUM_REGS];

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [4:0]  rs1, rs2, rd_q;
  logic [31:0] rs1_val, rs2_val, op2_dec;
  logic        is_op, is_opimm, is_shift, legal;

  // Decode straight off the offered word; only used on the accept edge.
  always_comb begin
    opcode   = instruction[6:0];
    funct3   = instruction[14:12];
    funct7   = instruction[31:25];
    rs1      = instruction[19:15];
    rs2      = instruction[24:20];
    rs1_val  = (rs1 == 5'd0) ? 32'd0 : regs_q[rs1];
    rs2_val  = (rs2 == 5'd0) ? 32'd0 : regs_q[rs2];
    is_op    = (opcode == 7'b0110011);
    is_opimm = (opcode == 7'b0010011);
    is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    legal    = (is_op && (funct7 == 7'd0)) || (is_opimm && (!is_shift || (funct7 == 7'd0)));
    if (is_op) begin
      op2_dec = is_shift ? {27'd0, rs2_val[4:0]} : rs2_val;
    end else begin
      op2_dec = is_shift ? {27'd0, instruction[24:20]}
                         : {{20{instruction[31]}}, instruction[31:20]};
    end
  end

  assign rd_q = instr_q[11:7];

  always_comb begin
    state_d   = state_q;
    instr_d   = instr_q;
    funct3_d  = funct3_q;
    op1_d     = op1_q;
    op2_d     = op2_q;
    illegal_d = 1'b0;
    regs_d    = regs_q;
    unique case (state_q)
      StIdle: begin
        if (instr_valid) begin
          instr_d = instruction;
          if (legal) begin
            funct3_d = funct3;
            op1_d    = rs1_val;
            op2_d    = op2_dec;
            state_d  = StIssue;
          end else begin
            illegal_d = 1'b1;
          end
        end
      end
      StIssue: state_d = StWait;
      StWait:  state_d = StWb;
      StWb: begin
        // alu_result is only driven meaningfully here, so it is sampled nowhere else.
        if (rd_q != 5'd0) regs_d[rd_q] = alu_result;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      instr_q   <= RESET_PC_TAG;
      funct3_q  <= 3'd0;
      op1_q     <= 32'd0;
      op2_q     <= 32'd0;
      illegal_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= 32'd0;
    end else begin
      state_q   <= state_d;
      instr_q   <= instr_d;
      funct3_q  <= funct3_d;
      op1_q     <= op1_d;
      op2_q     <= op2_d;
      illegal_q <= illegal_d;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= regs_d[i];
    end
  end

  assign instr_ready   = (state_q == StIdle);
  assign alu_enable    = (state_q == StIssue);
  assign done          = (state_q == StWb);
  assign illegal       = illegal_q;
  assign alu_funct3    = funct3_q;
  assign alu_operand_1 = op1_q;
  assign alu_operand_2 = op2_q;
  assign dbg_data      = (dbg_addr == 5'd0) ? 32'd0 : regs_q[dbg_addr];

  // instr_q doubles as the last-instruction debug register; only rd is consumed here.
  logic unused_instr;
  assign unused_instr = ^{instr_q[31:12], instr_q[6:0]};

endmodule
